// File: rtl/spin_display.sv
// spin_display: drives one 7-segment digit from the wheel position: a chase while spinning, a blink then hold on stop.
// Latency: every output is registered and reflects the next state and current inputs one cycle later.
// Backpressure: none; the block consumes tick_i/pos_i/running_i every cycle and never stalls.
module spin_display #(
  parameter int BLINK_DIV   = 4,
  parameter int BLINK_COUNT = 3,
  parameter int TARGET_POS  = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic [2:0] pos_i,
  input  logic       running_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       result_valid_o,
  output logic [2:0] result_o,
  output logic [3:0] hits_o
);

  typedef enum logic [1:0] {ST_SPIN, ST_BLINK, ST_HOLD} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(BLINK_DIV - 1);
  localparam logic [7:0] HALF_LAST = 8'(2 * BLINK_COUNT);
  localparam logic [2:0] TGT       = 3'(TARGET_POS);
  localparam logic [6:0] SEG_G     = 7'h40;

  // Positions 0..5 light segments a..f; 6 and 7 light nothing.
  function automatic logic [6:0] decode(input logic [2:0] p);
    logic [6:0] s;
    case (p)
      3'd0:    s = 7'h01;
      3'd1:    s = 7'h02;
      3'd2:    s = 7'h04;
      3'd3:    s = 7'h08;
      3'd4:    s = 7'h10;
      3'd5:    s = 7'h20;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  state_t     state_q, state_d;
  logic       running_q, running_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [7:0] half_cnt_q, half_cnt_d;
  logic       phase_q, phase_d;
  logic [2:0] result_q, result_d;
  logic [3:0] hits_q, hits_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       valid_q, valid_d;

  logic stop_edge;
  logic spin_edge;

  assign stop_edge = running_q & ~running_i;
  assign spin_edge = ~running_q & running_i;

  // Next-state logic: latch on stop, pace the blink on ticks, spin edge always wins.
  always_comb begin
    state_d    = state_q;
    running_d  = running_i;
    div_cnt_d  = div_cnt_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    result_d   = result_q;
    hits_d     = hits_q;
    case (state_q)
      ST_SPIN: begin
        if (stop_edge) begin
          result_d   = pos_i;
          div_cnt_d  = 8'd0;
          half_cnt_d = 8'd0;
          phase_d    = 1'b1;
          state_d    = ST_BLINK;
          if (pos_i == TGT && hits_q != 4'hf) hits_d = hits_q + 4'd1;
        end
      end
      ST_BLINK: begin
        if (spin_edge) begin
          state_d = ST_SPIN;
        end else if (tick_i) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d  = 8'd0;
            phase_d    = ~phase_q;
            half_cnt_d = half_cnt_q + 8'd1;
            if (half_cnt_d == HALF_LAST) state_d = ST_HOLD;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (spin_edge) state_d = ST_SPIN;
      end
      default: state_d = ST_SPIN;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track it one cycle later.
  always_comb begin
    seg_d   = decode(pos_i);
    dp_d    = 1'b0;
    valid_d = 1'b0;
    case (state_d)
      ST_BLINK: begin
        seg_d   = phase_d ? decode(result_d) : 7'h00;
        valid_d = 1'b1;
      end
      ST_HOLD: begin
        seg_d   = decode(result_d) | SEG_G;
        valid_d = 1'b1;
        dp_d    = (result_d == TGT);
      end
      default: ;
    endcase
  end

  // State and output registers; reset assumes the wheel was running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_SPIN;
      running_q  <= 1'b1;
      div_cnt_q  <= 8'd0;
      half_cnt_q <= 8'd0;
      phase_q    <= 1'b1;
      result_q   <= 3'd0;
      hits_q     <= 4'd0;
      seg_q      <= 7'h00;
      dp_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      div_cnt_q  <= div_cnt_d;
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      result_q   <= result_d;
      hits_q     <= hits_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      valid_q    <= valid_d;
    end
  end

  assign seg_o          = seg_q;
  assign dp_o           = dp_q;
  assign result_valid_o = valid_q;
  assign result_o       = result_q;
  assign hits_o         = hits_q;

endmodule

// File: tb/tb_spin_display.sv
// Testbench for spin_display: a behavioural model pushes expected outputs, a monitor pops and compares.
// Directed scenarios (chase, blink, hold, saturation, aborts, async reset) followed by random stimulus.
module tb_spin_display;

  localparam int BDIV = 2;
  localparam int BCNT = 2;
  localparam int TGT  = 0;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_i = 1'b0;
  logic [2:0] pos_i = 3'd0;
  logic       running_i = 1'b1;
  logic [6:0] seg_o;
  logic       dp_o;
  logic       result_valid_o;
  logic [2:0] result_o;
  logic [3:0] hits_o;

  spin_display #(.BLINK_DIV(BDIV), .BLINK_COUNT(BCNT), .TARGET_POS(TGT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .pos_i(pos_i), .running_i(running_i),
    .seg_o(seg_o), .dp_o(dp_o), .result_valid_o(result_valid_o), .result_o(result_o), .hits_o(hits_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Expected output word: {seg[6:0], dp, valid, result[2:0], hits[3:0]}
  logic [15:0] exp_q[$];

  // Reference model: mode 0 = spinning, 1 = blinking, 2 = holding.
  int m_mode = 0;
  int m_prev_run = 1;
  int m_ticks = 0;
  int m_result = 0;
  int m_hits = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s at %0t: got seg=%h dp=%b vld=%b res=%0d hits=%0d, required seg=%h dp=%b vld=%b res=%0d hits=%0d",
                  name, $time, act[15:9], act[8], act[7], act[6:4], act[3:0],
                  req[15:9], req[8], req[7], req[6:4], req[3:0]);
  endtask

  function automatic int seg_of(input int p);
    return (p < 6) ? (1 << p) : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev_run = 1; m_ticks = 0; m_result = 0; m_hits = 0;
  endtask

  task automatic model_step(input int t, input int p, input int r, output logic [15:0] e);
    int seg;
    bit stop, spin;
    stop = (m_prev_run == 1) && (r == 0);
    spin = (m_prev_run == 0) && (r == 1);
    if (m_mode == 0) begin
      if (stop) begin
        m_mode = 1; m_result = p; m_ticks = 0;
        if (p == TGT) m_hits = (m_hits + 1 > 15) ? 15 : m_hits + 1;
      end
    end else if (m_mode == 1) begin
      if (spin) m_mode = 0;
      else if (t != 0) begin
        m_ticks++;
        if (m_ticks == 2 * BDIV * BCNT) m_mode = 2;
      end
    end else begin
      if (spin) m_mode = 0;
    end
    m_prev_run = r;
    if (m_mode == 0)      seg = seg_of(p);
    else if (m_mode == 1) seg = (((m_ticks / BDIV) % 2) == 0) ? seg_of(m_result) : 0;
    else                  seg = seg_of(m_result) | 'h40;
    e = {7'(seg), (m_mode == 2 && m_result == TGT), (m_mode != 0), 3'(m_result), 4'(m_hits)};
  endtask

  task automatic step(input logic t, input logic [2:0] p, input logic r);
    logic [15:0] e;
    @(negedge clk_i);
    tick_i = t; pos_i = p; running_i = r;
    model_step(int'(t), int'(p), int'(r), e);
    exp_q.push_back(e);
  endtask

  // Stop at position p, then spend n cycles stopped with a tick every cycle.
  task automatic stop_at(input logic [2:0] p, input int n);
    step(1'b1, p, 1'b0);
    for (int i = 0; i < n; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0);
  endtask

  // Monitor: one expected word per driven cycle, compared just after the edge.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {seg_o, dp_o, result_valid_o, result_o, hits_o}, e);
      end
    end
  end

  initial begin
    #2;
    check("reset_outputs", {seg_o, dp_o, result_valid_o, result_o, hits_o}, 16'h0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();

    // Chase: positions 0..5 (and 6, 7) while spinning.
    for (int p = 0; p < 8; p++) step(1'b1, 3'(p), 1'b1);

    // Blink at 3 with full sequence into HOLD, idle a while, then spin again.
    step(1'b1, 3'd3, 1'b1);
    stop_at(3'd3, 12);
    step(1'b0, 3'd5, 1'b1);
    step(1'b1, 3'd1, 1'b1);

    // Stop at 6: blank blink, HOLD shows g only.
    step(1'b1, 3'd6, 1'b1);
    stop_at(3'd6, 10);
    step(1'b1, 3'd2, 1'b1);

    // Abort mid-blink after one tick.
    step(1'b1, 3'd2, 1'b1);
    stop_at(3'd2, 1);
    step(1'b1, 3'd4, 1'b1);
    step(1'b1, 3'd5, 1'b1);

    // Spin edge coincides with the final half-period tick.
    stop_at(3'd1, 7);
    step(1'b1, 3'd0, 1'b1);
    step(1'b1, 3'd3, 1'b1);

    // Stop-edge glitch outside SPIN and tick-free stretches.
    stop_at(3'd4, 2);
    step(1'b0, 3'd4, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    step(1'b0, 3'd4, 1'b0);

    // Five target hits, end in HOLD, then async reset away from any edge.
    step(1'b1, 3'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'd0, 1'b1);
      stop_at(3'd0, 10);
      if (k < 4) step(1'b1, 3'd0, 1'b1);
    end
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("async_reset", {seg_o, dp_o, result_valid_o, result_o, hits_o}, 16'h0000);
    model_reset();
    running_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Saturation: 16 stops at the target.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 3'd0, 1'b1);
      stop_at(3'd0, $urandom_range(0, 10));
      step(1'b1, 3'd0, 1'b1);
    end
    @(posedge clk_i);
    #2;
    check("hits_saturate", {12'h000, hits_o}, 16'h000f);

    // Random spins and stops.
    for (int r = 0; r < 60; r++) begin
      int ns, nt;
      ns = $urandom_range(1, 8);
      nt = $urandom_range(1, 14);
      for (int i = 0; i < ns; i++) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
      for (int i = 0; i < nt; i++) step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'b0);
    end
    step(1'b0, 3'd0, 1'b1);

    @(posedge clk_i);
    #3;
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
